msk_tof_driver: RTL and testbench
=================================

# msk_tof_driver

Share-domain driver and collector for the HPC3 masked Toffoli gadget (out = a·b ⊕ c, first-order-glitch-robust, latency 1). The block encodes plain bits a, b, c into d-share Boolean sharings, generates fresh gadget randomness from an internal PRNG, and sequences the gadget's two-cycle input timing. It then captures the output sharing and decodes it to a plain result behind valid/ready handshakes. It sits between the plain-domain controller and one gadget instance in characterization and self-test builds.

## Interface
- d, 2 (DEFAULTSHARES): share count; legal 2..7.
- RND, d*(d-1): gadget randomness width (hpc3rnd); derived, not overridable.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- seed_valid  in  1  load PRNG seed this cycle.
- seed  in  64  PRNG seed.
- in_valid / in_ready  in / out  1 / 1  plain-input handshake.
- in_a, in_b, in_c  in  1 each  plain operands.
- g_ina, g_inb, g_inc  out  d each  sharings for gadget cycle 0.
- g_ina_prev  out  d  sharing of a for gadget cycle 1.
- g_rnd  out  RND  fresh randomness for gadget cycle 0.
- g_out  in  d  gadget output sharing, valid in gadget cycle 1.
- out_valid / out_ready  out / in  1 / 1  result handshake.
- out_y  out  1  decoded result.
- out_shares  out  d  raw captured g_out (verification visibility).

## Operation
- FSM states: UNSEEDED, IDLE, ISSUE, WAIT, HOLD.
- UNSEEDED: in_ready = 0. seed_valid moves to IDLE.
- IDLE: in_ready = !seed_valid. seed_valid reloads the seed and stays in IDLE; a same-cycle in_valid is not accepted. Handshake → ISSUE.
- ISSUE lasts exactly 1 cycle, then → WAIT. WAIT lasts exactly 1 cycle, then → HOLD.
- HOLD: out_valid = 1. out_ready → IDLE.
- seed_valid is ignored in ISSUE, WAIT and HOLD.
- PRNG: 64-bit xorshift. Next state: s ^= s<<13; s ^= s>>7; s ^= s<<17.
  - A seed of 0 loads 64'h0123_4567_89AB_CDEF instead.
  - The PRNG advances exactly once per accepted input.
- Mask draw from the pre-advance state S:
  - m_a = S[0 +: d-1], m_b = S[d-1 +: d-1], m_c = S[2(d-1) +: d-1].
  - rnd = S[3(d-1) +: RND].
- Encoding for each x in {a, b, c}:
  - share i = m_x[i] for i < d-1.
  - share d-1 = x ⊕ XOR-reduce(m_x).
- Shares and rnd are registered at accept. No plain value is registered alongside them.
- Output gating (prevents stale-share recombination):
  - g_ina, g_inb, g_inc, g_rnd: driven from registers in ISSUE only, all-zero otherwise.
  - g_ina_prev: equals the a-sharing in WAIT only, zero otherwise.
- Capture: at the end of WAIT, out_shares ← g_out and out_y ← XOR-reduce(g_out). Both hold through HOLD.

## Timing
- Reset values: state UNSEEDED, PRNG state 0, all share/rnd registers 0. All outputs 0, including in_ready, out_valid, out_y and out_shares.
- Accept at edge t → ISSUE during cycle t+1 → WAIT during t+2 → out_valid from t+3.
- Maximum throughput is one result per 4 cycles, reached when out_ready is held high.
- out_valid, out_y and out_shares are stable while out_valid = 1 and out_ready = 0.
- rst_n low in any state: full return to reset values next edge; the seed is lost (UNSEEDED).

## Structure
- Package msk_tof_driver_pkg:
  - state enum.
  - RND/mask-width localparam functions of d.
  - zero-seed replacement constant.
  - xorshift shift amounts.
- Sub-module msk_prng64: seed load, advance strobe, 64-bit state output.
- Encoding, gating, FSM and decode live in the top module.

## Test plan
- d=2, seed 1, then a=1, b=1, c=0 → in cycle t+1: g_ina=2'b01, g_inb=2'b10, g_inc=2'b00, g_rnd=2'b00; with the gadget attached, out_y=1 at t+3.
- Exhaustive a/b/c (8 vectors), d=3 with gadget attached → out_y = a·b ⊕ c for every vector.
- After each of the 8 vectors, XOR-reduce(out_shares) = out_y; across 1000 random runs, no individual share equals the plain value with probability ≠ ½ ± 0.05.
- Seed 0 loaded → PRNG state equals 64'h0123_4567_89AB_CDEF. No load before in_valid → in_ready stays 0 for 20 cycles.
- out_ready held 0 for 10 cycles in HOLD → out_valid and out_y stable, in_ready=0; then release → IDLE next cycle. seed_valid pulsed in WAIT → PRNG unchanged.
- rst_n asserted during WAIT → next cycle all outputs 0, state UNSEEDED, no out_valid for that evaluation.

Source files
------------

// File: rtl/msk_tof_driver_pkg.sv
// Shared types and constants for the masked Toffoli gadget driver.
// Width helpers are functions of the share count so every file derives them the same way.
package msk_tof_driver_pkg;

  typedef enum logic [2:0] {
    ST_UNSEEDED = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_HOLD     = 3'd4
  } state_e;

  localparam logic [63:0] PRNG_ZERO_SEED = 64'h0123_4567_89AB_CDEF;

  localparam int XS_SHL_A = 13;
  localparam int XS_SHR   = 7;
  localparam int XS_SHL_B = 17;

  function automatic int mask_width(input int d);
    return d - 1;
  endfunction

  function automatic int rnd_width(input int d);
    return d * (d - 1);
  endfunction

endpackage

// File: rtl/msk_prng64.sv
// 64-bit xorshift generator: seed load takes priority over the advance strobe.
// An all-zero seed would lock xorshift at zero, so it is replaced by a fixed constant.
module msk_prng64
  import msk_tof_driver_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [63:0] seed_i,
  input  logic        step_i,
  output logic [63:0] state_o
);

  logic [63:0] state_q, state_d;
  logic [63:0] xs_1, xs_2, xs_3;

  always_comb begin
    xs_1    = state_q ^ (state_q << XS_SHL_A);
    xs_2    = xs_1 ^ (xs_1 >> XS_SHR);
    xs_3    = xs_2 ^ (xs_2 << XS_SHL_B);
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == 64'd0) ? PRNG_ZERO_SEED : seed_i;
    end else if (step_i) begin
      state_d = xs_3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= 64'd0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/msk_tof_driver.sv
// Encodes plain a/b/c into D-share sharings, sequences the HPC3 Toffoli gadget's
// two-cycle input timing, then captures and decodes its output sharing.
//
//   state    | meaning
//   UNSEEDED | PRNG not loaded, inputs refused
//   IDLE     | ready for operands, seed may be reloaded
//   ISSUE    | gadget cycle 0: shares and randomness driven
//   WAIT     | gadget cycle 1: a-sharing re-driven, output captured at end
//   HOLD     | decoded result presented until out_ready
module msk_tof_driver
  import msk_tof_driver_pkg::*;
#(
  parameter int D = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 seed_valid_i,
  input  logic [63:0]          seed_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_a_i,
  input  logic                 in_b_i,
  input  logic                 in_c_i,
  output logic [D-1:0]         g_ina_o,
  output logic [D-1:0]         g_inb_o,
  output logic [D-1:0]         g_inc_o,
  output logic [D-1:0]         g_ina_prev_o,
  output logic [D*(D-1)-1:0]   g_rnd_o,
  input  logic [D-1:0]         g_out_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_y_o,
  output logic [D-1:0]         out_shares_o
);

  localparam int MW   = mask_width(D);
  localparam int RND  = rnd_width(D);
  localparam int USED = 3 * MW + RND;

  state_e state_q, state_d;

  logic [63:0]    prng_state;
  logic           accept;
  logic           seed_load;
  logic [D-1:0]   sha_q, sha_d, shb_q, shb_d, shc_q, shc_d;
  logic [RND-1:0] rnd_q, rnd_d;
  logic [D-1:0]   out_shares_q;
  logic           out_y_q;
  logic [63-USED:0] unused_prng;

  function automatic logic [D-1:0] encode(input logic x, input logic [MW-1:0] m);
    return {x ^ (^m), m};
  endfunction

  assign in_ready_o = (state_q == ST_IDLE) && !seed_valid_i;
  assign accept     = in_ready_o && in_valid_i;
  assign seed_load  = seed_valid_i && ((state_q == ST_UNSEEDED) || (state_q == ST_IDLE));

  msk_prng64 u_prng (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (seed_load),
    .seed_i  (seed_i),
    .step_i  (accept),
    .state_o (prng_state)
  );

  assign unused_prng = prng_state[63:USED];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_UNSEEDED: if (seed_valid_i) state_d = ST_IDLE;
      ST_IDLE:     if (accept) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = ST_WAIT;
      ST_WAIT:     state_d = ST_HOLD;
      ST_HOLD:     if (out_ready_i) state_d = ST_IDLE;
      default:     state_d = ST_UNSEEDED;
    endcase
  end

  // Masks come from the pre-advance PRNG state; the advance happens on the same edge.
  always_comb begin
    sha_d = sha_q;
    shb_d = shb_q;
    shc_d = shc_q;
    rnd_d = rnd_q;
    if (accept) begin
      sha_d = encode(in_a_i, prng_state[0 +: MW]);
      shb_d = encode(in_b_i, prng_state[MW +: MW]);
      shc_d = encode(in_c_i, prng_state[2*MW +: MW]);
      rnd_d = prng_state[3*MW +: RND];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_UNSEEDED;
      sha_q        <= '0;
      shb_q        <= '0;
      shc_q        <= '0;
      rnd_q        <= '0;
      out_shares_q <= '0;
      out_y_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shc_q   <= shc_d;
      rnd_q   <= rnd_d;
      if (state_q == ST_WAIT) begin
        out_shares_q <= g_out_i;
        out_y_q      <= ^g_out_i;
      end
    end
  end

  // Shares reach the gadget only in their own cycle so stale sharings never recombine.
  always_comb begin
    g_ina_o      = '0;
    g_inb_o      = '0;
    g_inc_o      = '0;
    g_rnd_o      = '0;
    g_ina_prev_o = '0;
    if (state_q == ST_ISSUE) begin
      g_ina_o = sha_q;
      g_inb_o = shb_q;
      g_inc_o = shc_q;
      g_rnd_o = rnd_q;
    end
    if (state_q == ST_WAIT) begin
      g_ina_prev_o = sha_q;
    end
  end

  assign out_valid_o  = (state_q == ST_HOLD);
  assign out_y_o      = out_y_q;
  assign out_shares_o = out_shares_q;

endmodule

// File: tb/tb_msk_tof_driver.sv
// Bench for msk_tof_driver at D=2 and D=3 sharing one stimulus stream, with a
// behavioural latency-1 Toffoli gadget per instance and a plain-arithmetic PRNG/encoding model.
module tb_msk_tof_driver;

  localparam logic [63:0] ZSEED = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_valid;
  logic [63:0] seed;
  logic        in_valid, in_a, in_b, in_c, out_ready;

  logic        in_ready2, out_valid2, out_y2;
  logic [1:0]  g2_ina, g2_inb, g2_inc, g2_ina_prev, g2_rnd, g2_out, out_sh2;
  logic        in_ready3, out_valid3, out_y3;
  logic [2:0]  g3_ina, g3_inb, g3_inc, g3_ina_prev, g3_out, out_sh3;
  logic [5:0]  g3_rnd;
  logic [1:0]  gad_r;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] mdl_s;
  int          cnt_eq [3];
  logic [1:0]  obs_ina2, obs_inb2, obs_inc2, obs_rnd2;
  logic        obs_y2;

  always #5 clk = ~clk;

  msk_tof_driver #(.D(2)) u_d2 (
    .clk_i(clk), .rst_n_i(rst_n), .seed_valid_i(seed_valid), .seed_i(seed),
    .in_valid_i(in_valid), .in_ready_o(in_ready2), .in_a_i(in_a), .in_b_i(in_b), .in_c_i(in_c),
    .g_ina_o(g2_ina), .g_inb_o(g2_inb), .g_inc_o(g2_inc), .g_ina_prev_o(g2_ina_prev),
    .g_rnd_o(g2_rnd), .g_out_i(g2_out), .out_valid_o(out_valid2), .out_ready_i(out_ready),
    .out_y_o(out_y2), .out_shares_o(out_sh2)
  );

  msk_tof_driver #(.D(3)) u_d3 (
    .clk_i(clk), .rst_n_i(rst_n), .seed_valid_i(seed_valid), .seed_i(seed),
    .in_valid_i(in_valid), .in_ready_o(in_ready3), .in_a_i(in_a), .in_b_i(in_b), .in_c_i(in_c),
    .g_ina_o(g3_ina), .g_inb_o(g3_inb), .g_inc_o(g3_inc), .g_ina_prev_o(g3_ina_prev),
    .g_rnd_o(g3_rnd), .g_out_i(g3_out), .out_valid_o(out_valid3), .out_ready_i(out_ready),
    .out_y_o(out_y3), .out_shares_o(out_sh3)
  );

  // Gadget stand-in: registers a fresh random sharing of a*b^c (latency 1).
  always @(negedge clk) gad_r <= 2'($urandom);
  always @(posedge clk) begin
    g2_out <= {gad_r[0] ^ ((^g2_ina & ^g2_inb) ^ ^g2_inc), gad_r[0]};
    g3_out <= {(^gad_r) ^ ((^g3_ina & ^g3_inb) ^ ^g3_inc), gad_r};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xs(input logic [63:0] s);
    logic [63:0] t;
    t = s;
    t = t ^ (t << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic logic [2:0] enc3(input logic x, input logic [1:0] m);
    return {x ^ m[1] ^ m[0], m};
  endfunction

  function automatic logic [1:0] enc2(input logic x, input logic m);
    return {x ^ m, m};
  endfunction

  task automatic load_seed(input logic [63:0] sv, input logic with_valid);
    seed_valid = 1'b1;
    seed       = sv;
    in_valid   = with_valid;
    #1;
    chk("in_ready_during_seed", {in_ready3, in_ready2}, 2'b00);
    @(negedge clk);
    seed_valid = 1'b0;
    in_valid   = 1'b0;
    mdl_s      = (sv == 64'd0) ? ZSEED : sv;
    #1;
    chk("idle_after_seed", {in_ready3, in_ready2}, 2'b11);
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the following IDLE cycle.
  task automatic do_txn(input logic a, input logic b, input logic c, input int hold, input bit pulse);
    logic [2:0] ea3, eb3, ec3, sh3;
    logic [5:0] er3;
    logic [1:0] ea2, eb2, ec2, er2, sh2;
    logic       y;
    y   = (a & b) ^ c;
    ea3 = enc3(a, mdl_s[1:0]);
    eb3 = enc3(b, mdl_s[3:2]);
    ec3 = enc3(c, mdl_s[5:4]);
    er3 = mdl_s[11:6];
    ea2 = enc2(a, mdl_s[0]);
    eb2 = enc2(b, mdl_s[1]);
    ec2 = enc2(c, mdl_s[2]);
    er2 = mdl_s[4:3];
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c;
    #1;
    chk("in_ready_idle", {in_ready3, in_ready2}, 2'b11);
    @(negedge clk);
    in_valid = 1'b0;
    chk("issue_ina3", g3_ina, ea3);
    chk("issue_inb3", g3_inb, eb3);
    chk("issue_inc3", g3_inc, ec3);
    chk("issue_rnd3", g3_rnd, er3);
    chk("issue_d2", {g2_ina, g2_inb, g2_inc, g2_rnd}, {ea2, eb2, ec2, er2});
    chk("issue_prev_zero", {g3_ina_prev, g2_ina_prev}, 0);
    chk("issue_no_valid", {out_valid3, out_valid2, in_ready3}, 0);
    obs_ina2 = g2_ina; obs_inb2 = g2_inb; obs_inc2 = g2_inc; obs_rnd2 = g2_rnd;
    for (int i = 0; i < 3; i++) if (g3_ina[i] == a) cnt_eq[i]++;
    mdl_s = xs(mdl_s);
    @(negedge clk);
    if (pulse) begin
      seed_valid = 1'b1;
      seed       = {$urandom, $urandom};
    end
    chk("wait_prev3", g3_ina_prev, ea3);
    chk("wait_prev2", g2_ina_prev, ea2);
    chk("wait_gated", {g3_ina, g3_inb, g3_inc, g3_rnd, g2_ina, g2_inb, g2_inc, g2_rnd}, 0);
    chk("wait_no_valid", {out_valid3, out_valid2}, 0);
    sh3 = g3_out;
    sh2 = g2_out;
    @(negedge clk);
    seed_valid = 1'b0;
    for (int k = 0; k <= hold; k++) begin
      chk("hold_valid", {out_valid3, out_valid2}, 2'b11);
      chk("hold_y3", out_y3, y);
      chk("hold_y2", out_y2, y);
      chk("hold_sh3", out_sh3, sh3);
      chk("hold_sh2", out_sh2, sh2);
      chk("hold_sh_decode", ^out_sh3, y);
      chk("hold_not_ready", {in_ready3, in_ready2}, 0);
      chk("hold_gated", {g3_ina, g3_ina_prev, g2_ina, g2_ina_prev}, 0);
      if (k == hold) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    obs_y2 = y;
    chk("release_idle", {out_valid3, out_valid2, in_ready3, in_ready2}, 4'b0011);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] rs;
    logic        ra, rb, rc;
    rst_n = 1'b0; seed_valid = 1'b0; seed = '0;
    in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; in_c = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cnt_eq[i] = 0;
    mdl_s = '0;
    repeat (2) @(negedge clk);
    chk("rst_d3", {in_ready3, out_valid3, out_y3, out_sh3, g3_ina, g3_inb, g3_inc, g3_ina_prev, g3_rnd}, 0);
    chk("rst_d2", {in_ready2, out_valid2, out_y2, out_sh2, g2_ina, g2_inb, g2_inc, g2_ina_prev, g2_rnd}, 0);
    rst_n = 1'b1;

    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("unseeded_ready", {in_ready3, in_ready2, out_valid3}, 0);
    end
    in_valid = 1'b0;

    load_seed(64'd1, 1'b1);
    do_txn(1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk("d2_seed1_ina", obs_ina2, 2'b01);
    chk("d2_seed1_inb", obs_inb2, 2'b10);
    chk("d2_seed1_inc", obs_inc2, 2'b00);
    chk("d2_seed1_rnd", obs_rnd2, 2'b00);
    chk("d2_seed1_y", obs_y2, 1'b1);

    load_seed(64'd0, 1'b0);
    do_txn(1'b0, 1'b0, 1'b0, 0, 1'b0);

    for (int v = 0; v < 8; v++) begin
      do_txn(v[2], v[1], v[0], (v == 3) ? 10 : 0, v == 5);
    end

    in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1; in_c = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_wait_d3", {in_ready3, out_valid3, out_y3, out_sh3, g3_ina, g3_inb, g3_inc, g3_ina_prev, g3_rnd}, 0);
    chk("rst_wait_d2", {in_ready2, out_valid2, out_y2, out_sh2, g2_ina, g2_ina_prev, g2_rnd}, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_wait_unseeded", {in_ready3, in_ready2, out_valid3, out_valid2}, 0);
    end
    in_valid = 1'b0;

    rs = {$urandom, $urandom};
    load_seed(rs, 1'b0);
    for (int i = 0; i < 3; i++) cnt_eq[i] = 0;
    for (int n = 0; n < 1000; n++) begin
      ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom);
      do_txn(ra, rb, rc, $urandom_range(0, 2), 1'($urandom));
    end
    for (int i = 0; i < 3; i++) begin
      chk("share_bias", (cnt_eq[i] >= 450) && (cnt_eq[i] <= 550), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
